sensor_scan_ctrl: RTL

// Round-robin scheduler that shares one debounce/decision engine across N_CH raw sensor inputs.

---
 rtl/sensor_pkg.sv | 18 +
 rtl/sensor_deb_cnt.sv | 38 +++
 rtl/sensor_scan_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sensor_pkg.sv
// Shared types and defaults for the round-robin sensor scanner.
// Debounce counters live per channel; scheduling lives in the top.
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_state_t;

  localparam int DEF_DEB_CNT = 3;
  localparam int DEF_DWELL   = 2;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_deb_cnt.sv
// Per-channel run counter of consecutive samples disagreeing with Z.
// Raises commit on the sample that completes the run.
module sensor_deb_cnt
  import sensor_pkg::*;
#(
  parameter  int DEB_CNT = DEF_DEB_CNT,
  localparam int NW      = $clog2(DEB_CNT + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          smp,
  input  logic          s,
  input  logic          z,
  output logic [NW-1:0] cnt,
  output logic          commit
);

  localparam logic [NW-1:0] LAST = NW'(DEB_CNT - 1);

  assign commit = smp && (s != z) && (cnt == LAST);

  // A blocked commit keeps cnt at LAST until load clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (smp) begin
      if (s == z) begin
        cnt <= '0;
      end else if (cnt != LAST) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Round-robin scan of N_CH sensors through one debounce engine.
// Each Z flip is reported once over a VLD/ACK event port.
module sensor_scan_ctrl
  import sensor_pkg::*;
#(
  parameter  int N_CH    = 4,
  parameter  int DEB_CNT = DEF_DEB_CNT,
  parameter  int DWELL   = DEF_DWELL,
  localparam int CW      = cw(N_CH)
) (
  input  logic            CLK,
  input  logic            MR_N,
  input  logic            EN,
  input  logic [N_CH-1:0] X,
  output logic [CW-1:0]   SEL,
  output logic [N_CH-1:0] Z,
  output logic            EVT_VLD,
  output logic [CW-1:0]   EVT_CH,
  output logic            EVT_LVL,
  input  logic            EVT_ACK
);

  localparam int NW = $clog2(DEB_CNT + 1);
  localparam int DW = cw(DWELL);

  localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] SLAST = CW'(N_CH - 1);
  localparam logic [NW-1:0] CLAST = NW'(DEB_CNT - 1);

  scan_state_t state, nxt;

  logic [DW-1:0]   dwell;
  logic [NW-1:0]   cnt [N_CH];
  logic [N_CH-1:0] smp_v;
  logic [N_CH-1:0] load_v;
  logic [N_CH-1:0] flag_v;

  logic s;
  logic smp;
  logic ok;
  logic req;
  logic pend;
  logic blocked;
  logic commit;
  logic adv;
  logic dw_clr;
  logic dw_inc;

  // In HOLD the pending sample is simply the inverse of the held Z.
  assign s       = (state == HOLD) ? ~Z[SEL] : ~X[SEL];
  assign smp     = (state == SCAN) && EN && (dwell == DLAST);
  assign ok      = !EVT_VLD || EVT_ACK;
  assign req     = |flag_v;
  assign pend    = (cnt[SEL] == CLAST);
  assign blocked = smp && req && !ok;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign smp_v[i]  = smp && (SEL == CW'(i));
    assign load_v[i] = commit && (SEL == CW'(i));

    sensor_deb_cnt #(
      .DEB_CNT(DEB_CNT)
    ) u_deb (
      .clk   (CLK),
      .rst_n (MR_N),
      .load  (load_v[i]),
      .smp   (smp_v[i]),
      .s     (s),
      .z     (Z[i]),
      .cnt   (cnt[i]),
      .commit(flag_v[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (!MR_N) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (EN) nxt = SCAN;
      SCAN: begin
        if (!EN) begin
          nxt = IDLE;
        end else if (blocked) begin
          nxt = HOLD;
        end
      end
      HOLD: if (EVT_ACK) nxt = EN ? SCAN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    commit = 1'b0;
    adv    = 1'b0;
    dw_clr = 1'b0;
    dw_inc = 1'b0;
    unique case (1'b1)
      state == IDLE: dw_clr = EN;
      state == SCAN: begin
        if (smp) begin
          commit = req && ok;
          adv    = !req || ok;
          dw_clr = adv;
        end else begin
          dw_inc = EN;
        end
      end
      state == HOLD: begin
        commit = pend && EVT_ACK;
        adv    = commit;
        dw_clr = commit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!MR_N) begin
      dwell   <= '0;
      SEL     <= '0;
      Z       <= '0;
      EVT_VLD <= 1'b0;
      EVT_CH  <= '0;
      EVT_LVL <= 1'b0;
    end else begin
      if (dw_clr) begin
        dwell <= '0;
      end else if (dw_inc) begin
        dwell <= dwell + 1'b1;
      end
      if (adv) begin
        SEL <= (SEL == SLAST) ? '0 : SEL + 1'b1;
      end
      if (commit) begin
        Z[SEL]  <= s;
        EVT_VLD <= 1'b1;
        EVT_CH  <= SEL;
        EVT_LVL <= s;
      end else if (EVT_ACK) begin
        EVT_VLD <= 1'b0;
      end
    end
  end

endmodule
